uart_tx: RTL

UART transmitter: serialises bytes from a valid/ready stream onto the FPGA `tx` pin as 8N1 frames (1 start, 8 data LSB-first, 1 stop). It is the transmit counterpart to `uart_rx` and uses the same bit timing, so a `uart_tx` output looped into `uart_rx` reproduces the byte stream. A one-entry holding register lets the producer queue the next byte while the current frame shifts out. Back-to-back frames leave no idle gap.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_baud_gen.sv | 18 +
 rtl/uart_tx.sv | 95 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, frame constants and bit-timing helper
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with a one-cycle tick on the last cycle of each bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  output logic tick_o
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign tick_o = !clear_i && cnt == LAST;
  // count 0..CLKS_PER_BIT-1, wrapping at the bit boundary; clear holds it at the start of a bit
  always_ff @(posedge clk_i)
    if (!reset_ni || clear_i || tick_o) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serialiser with a one-entry holding register for gap-free streaming
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       valid_i,
  input  logic [7:0] byte_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  uart_state_e state;
  logic [7:0] shift, hold;
  logic       hold_full, tick, accept, stop_end, load_direct;
  logic [2:0] idx;
  assign ready_o     = reset_ni && !hold_full;
  assign accept      = valid_i && ready_o;
  assign stop_end    = state == STOP && tick;
  assign load_direct = accept && (state == IDLE || stop_end);
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clear_i (state == IDLE),
    .tick_o  (tick)
  );
  // frame sequencer: start, eight data bits LSB first, stop, then refill from hold or the input
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state     <= IDLE;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      idx       <= '0;
      tx_o      <= 1'b1;
      busy_o    <= 1'b0;
    end else begin
      if (accept && !load_direct) begin
        hold      <= byte_i;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE:
          if (accept) begin
            shift  <= byte_i;
            state  <= START;
            tx_o   <= 1'b0;
            busy_o <= 1'b1;
          end
        START:
          if (tick) begin
            state <= DATA;
            idx   <= '0;
            tx_o  <= shift[0];
          end
        DATA:
          if (tick) begin
            if (idx == LAST_BIT) begin
              state <= STOP;
              tx_o  <= 1'b1;
            end else begin
              shift <= shift >> 1;
              idx   <= idx + 3'd1;
              tx_o  <= shift[1];
            end
          end
        STOP:
          if (tick) begin
            if (hold_full) begin
              shift     <= hold;
              hold_full <= 1'b0;
              state     <= START;
              tx_o      <= 1'b0;
            end else if (accept) begin
              shift <= byte_i;
              state <= START;
              tx_o  <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
